// File: rtl/board_state.sv
// Tic-tac-toe board: holds nine two-bit cells and checks legality of each write.
// Detects lines, fill and winner, and flags rejected computer moves.
module board_state (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        pp_i,
    input  logic        cp_i,
    input  logic [3:0]  player_pos_i,
    input  logic [3:0]  comp_pos_i,
    output logic [17:0] cells_o,
    output logic        wrong_move_o,
    output logic        filled_o,
    output logic        win_o,
    output logic [1:0]  winner_o,
    output logic [3:0]  move_count_o,
    output logic        comp_err_o
);

    localparam logic [1:0] OWN_NONE   = 2'b00;
    localparam logic [1:0] OWN_PLAYER = 2'b01;
    localparam logic [1:0] OWN_COMP   = 2'b10;
    localparam logic [3:0] CNT_FULL   = 4'd9;

    logic [17:0] cells_q, cells_d;
    logic [3:0]  count_q, count_d;
    logic        comp_err_q, comp_err_d;

    logic        player_pos_ok, comp_pos_ok;
    logic [1:0]  player_tgt, comp_tgt;
    logic        comp_ok;
    logic        player_line, comp_line;
    logic [1:0]  line_own [8];
    logic [3:0]  count_inc;

    function automatic logic pos_valid(input logic [3:0] pos);
        return (pos >= 4'd1) && (pos <= 4'd9);
    endfunction

    // Out-of-range positions read as empty; legality is decided by pos_valid.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] pos);
        logic [1:0] r;
        r = OWN_NONE;
        for (int k = 1; k <= 9; k++) begin
            if (pos == 4'(k)) begin
                r = b[2*k-2 +: 2];
            end
        end
        return r;
    endfunction

    function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] pos,
                                             input logic [1:0] val);
        logic [17:0] r;
        r = b;
        for (int k = 1; k <= 9; k++) begin
            if (pos == 4'(k)) begin
                r[2*k-2 +: 2] = val;
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] line_owner(input logic [17:0] b, input logic [3:0] a,
                                              input logic [3:0] m, input logic [3:0] c);
        logic [1:0] va, vm, vc;
        va = cell_at(b, a);
        vm = cell_at(b, m);
        vc = cell_at(b, c);
        return ((va == vm) && (vm == vc)) ? va : OWN_NONE;
    endfunction

    always_comb begin
        line_own[0] = line_owner(cells_q, 4'd1, 4'd2, 4'd3);
        line_own[1] = line_owner(cells_q, 4'd4, 4'd5, 4'd6);
        line_own[2] = line_owner(cells_q, 4'd7, 4'd8, 4'd9);
        line_own[3] = line_owner(cells_q, 4'd1, 4'd4, 4'd7);
        line_own[4] = line_owner(cells_q, 4'd2, 4'd5, 4'd8);
        line_own[5] = line_owner(cells_q, 4'd3, 4'd6, 4'd9);
        line_own[6] = line_owner(cells_q, 4'd1, 4'd5, 4'd9);
        line_own[7] = line_owner(cells_q, 4'd3, 4'd5, 4'd7);
    end

    always_comb begin
        player_line = 1'b0;
        comp_line   = 1'b0;
        for (int l = 0; l < 8; l++) begin
            player_line = player_line | (line_own[l] == OWN_PLAYER);
            comp_line   = comp_line   | (line_own[l] == OWN_COMP);
        end
    end

    assign win_o    = player_line | comp_line;
    // Player takes precedence if both owners somehow hold a line.
    assign winner_o = player_line ? OWN_PLAYER : (comp_line ? OWN_COMP : OWN_NONE);

    assign player_pos_ok = pos_valid(player_pos_i);
    assign comp_pos_ok   = pos_valid(comp_pos_i);
    assign player_tgt    = cell_at(cells_q, player_pos_i);
    assign comp_tgt      = cell_at(cells_q, comp_pos_i);

    assign wrong_move_o = pp_i & (~player_pos_ok | (player_tgt != OWN_NONE) | win_o);
    assign comp_ok      = cp_i & ~pp_i & comp_pos_ok & (comp_tgt == OWN_NONE) & ~win_o;

    assign count_inc = (count_q == CNT_FULL) ? count_q : count_q + 4'd1;

    always_comb begin
        cells_d    = cells_q;
        count_d    = count_q;
        comp_err_d = comp_err_q;
        if (clear_i) begin
            cells_d    = '0;
            count_d    = '0;
            comp_err_d = 1'b0;
        end else if (pp_i) begin
            if (!wrong_move_o) begin
                cells_d = set_cell(cells_q, player_pos_i, OWN_PLAYER);
                count_d = count_inc;
            end
        end else if (cp_i) begin
            if (comp_ok) begin
                cells_d = set_cell(cells_q, comp_pos_i, OWN_COMP);
                count_d = count_inc;
            end else begin
                comp_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cells_q    <= '0;
            count_q    <= '0;
            comp_err_q <= 1'b0;
        end else begin
            cells_q    <= cells_d;
            count_q    <= count_d;
            comp_err_q <= comp_err_d;
        end
    end

    assign cells_o      = cells_q;
    assign move_count_o = count_q;
    assign comp_err_o   = comp_err_q;
    assign filled_o     = (count_q == CNT_FULL);

endmodule

// File: tb/tb_board_state.sv
// Directed, table-driven bench for board_state: each vector is one clock of
// stimulus with the expected wrong_move before the edge and board state after.
module tb_board_state;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear, pp, cp;
    logic [3:0]  player_pos, comp_pos;
    logic [17:0] cells;
    logic        wrong_move, filled, win, comp_err;
    logic [1:0]  winner;
    logic [3:0]  move_count;

    int errors = 0;
    int checks = 0;

    board_state dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .pp_i         (pp),
        .cp_i         (cp),
        .player_pos_i (player_pos),
        .comp_pos_i   (comp_pos),
        .cells_o      (cells),
        .wrong_move_o (wrong_move),
        .filled_o     (filled),
        .win_o        (win),
        .winner_o     (winner),
        .move_count_o (move_count),
        .comp_err_o   (comp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          clr, p, c;
        logic [3:0]  ppos, cpos;
        bit          wrong;
        logic [17:0] cells;
        logic [3:0]  cnt;
        bit          win;
        logic [1:0]  wnr;
        bit          fil, cerr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit clr, bit p, bit c, int ppos, int cpos, bit wrong,
                                int cl, int cnt, bit w, int wnr, bit fil, bit cerr);
        vec_t v;
        v.clr = clr; v.p = p; v.c = c;
        v.ppos = 4'(ppos); v.cpos = 4'(cpos);
        v.wrong = wrong; v.cells = 18'(cl); v.cnt = 4'(cnt);
        v.win = w; v.wnr = 2'(wnr); v.fil = fil; v.cerr = cerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input vec_t v);
        chk({tag, " cells"},      32'(cells),      32'(v.cells));
        chk({tag, " move_count"}, 32'(move_count), 32'(v.cnt));
        chk({tag, " win"},        32'(win),        32'(v.win));
        chk({tag, " winner"},     32'(winner),     32'(v.wnr));
        chk({tag, " filled"},     32'(filled),     32'(v.fil));
        chk({tag, " comp_err"},   32'(comp_err),   32'(v.cerr));
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        clear = v.clr; pp = v.p; cp = v.c;
        player_pos = v.ppos; comp_pos = v.cpos;
        #1 chk($sformatf("v%0d wrong_move", idx), 32'(wrong_move), 32'(v.wrong));
        @(posedge clk);
        #1 chk_state($sformatf("v%0d", idx), v);
    endtask

    task automatic idle();
        clear = 1'b0; pp = 1'b0; cp = 1'b0; player_pos = '0; comp_pos = '0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;

        // Legality and occupancy
        vq.push_back(mk(0,1,0, 5,0, 0, 'h00100, 1, 0,0,0,0));
        vq.push_back(mk(0,1,0, 5,0, 1, 'h00100, 1, 0,0,0,0));
        vq.push_back(mk(0,1,0, 0,0, 1, 'h00100, 1, 0,0,0,0));
        vq.push_back(mk(0,1,0,12,0, 1, 'h00100, 1, 0,0,0,0));
        vq.push_back(mk(1,0,0, 0,0, 0, 'h00000, 0, 0,0,0,0));
        // Player wins on the top row, board then frozen
        vq.push_back(mk(0,1,0, 1,0, 0, 'h00001, 1, 0,0,0,0));
        vq.push_back(mk(0,0,1, 0,4, 0, 'h00081, 2, 0,0,0,0));
        vq.push_back(mk(0,1,0, 2,0, 0, 'h00085, 3, 0,0,0,0));
        vq.push_back(mk(0,0,1, 0,5, 0, 'h00285, 4, 0,0,0,0));
        vq.push_back(mk(0,1,0, 3,0, 0, 'h00295, 5, 1,1,0,0));
        vq.push_back(mk(0,1,0, 6,0, 1, 'h00295, 5, 1,1,0,0));
        vq.push_back(mk(0,0,1, 0,6, 0, 'h00295, 5, 1,1,0,1));
        vq.push_back(mk(1,0,0, 0,0, 0, 'h00000, 0, 0,0,0,0));
        // Drawn game: P1 C2 P3 C5 P4 C6 P8 C7 P9
        vq.push_back(mk(0,1,0, 1,0, 0, 'h00001, 1, 0,0,0,0));
        vq.push_back(mk(0,0,1, 0,2, 0, 'h00009, 2, 0,0,0,0));
        vq.push_back(mk(0,1,0, 3,0, 0, 'h00019, 3, 0,0,0,0));
        vq.push_back(mk(0,0,1, 0,5, 0, 'h00219, 4, 0,0,0,0));
        vq.push_back(mk(0,1,0, 4,0, 0, 'h00259, 5, 0,0,0,0));
        vq.push_back(mk(0,0,1, 0,6, 0, 'h00A59, 6, 0,0,0,0));
        vq.push_back(mk(0,1,0, 8,0, 0, 'h04A59, 7, 0,0,0,0));
        vq.push_back(mk(0,0,1, 0,7, 0, 'h06A59, 8, 0,0,0,0));
        vq.push_back(mk(0,1,0, 9,0, 0, 'h16A59, 9, 0,0,1,0));
        vq.push_back(mk(0,1,0, 5,0, 1, 'h16A59, 9, 0,0,1,0));
        vq.push_back(mk(0,0,1, 0,0, 0, 'h16A59, 9, 0,0,1,1));
        vq.push_back(mk(1,0,0, 0,0, 0, 'h00000, 0, 0,0,0,0));
        // Computer wins on the 3-5-7 diagonal
        vq.push_back(mk(0,1,0, 1,0, 0, 'h00001, 1, 0,0,0,0));
        vq.push_back(mk(0,0,1, 0,3, 0, 'h00021, 2, 0,0,0,0));
        vq.push_back(mk(0,1,0, 2,0, 0, 'h00025, 3, 0,0,0,0));
        vq.push_back(mk(0,0,1, 0,5, 0, 'h00225, 4, 0,0,0,0));
        vq.push_back(mk(0,1,0, 4,0, 0, 'h00265, 5, 0,0,0,0));
        vq.push_back(mk(0,0,1, 0,7, 0, 'h02265, 6, 1,2,0,0));
        vq.push_back(mk(0,0,1, 0,9, 0, 'h02265, 6, 1,2,0,1));
        vq.push_back(mk(1,0,0, 0,0, 0, 'h00000, 0, 0,0,0,0));
        // pp and cp together, then clear winning over a legal pp
        vq.push_back(mk(0,1,1, 5,1, 0, 'h00100, 1, 0,0,0,0));
        vq.push_back(mk(0,0,1, 0,5, 0, 'h00100, 1, 0,0,0,1));
        vq.push_back(mk(0,1,1, 9,0, 0, 'h10100, 2, 0,0,0,1));
        vq.push_back(mk(1,1,0, 3,0, 0, 'h00000, 0, 0,0,0,0));

        // Combinational outputs while held in reset
        #2;
        pp = 1'b1; player_pos = 4'd0;
        #1 chk("reset wrong_move invalid pos", 32'(wrong_move), 32'd1);
        player_pos = 4'd5;
        #1 chk("reset wrong_move valid pos", 32'(wrong_move), 32'd0);
        chk_state("reset", mk(0,0,0,0,0,0, 0,0, 0,0,0,0));
        idle();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], i);
        end

        // Asynchronous reset between edges mid-game
        apply(mk(0,1,0, 1,0, 0, 'h00001, 1, 0,0,0,0), 100);
        apply(mk(0,0,1, 0,1, 0, 'h00001, 1, 0,0,0,1), 101);
        @(negedge clk);
        idle();
        pp = 1'b1; player_pos = 4'd2;
        #1 rst_n = 1'b0;
        #1 chk_state("async reset", mk(0,0,0,0,0,0, 0,0, 0,0,0,0));
        @(posedge clk);
        #1 chk("reset held cells", 32'(cells), 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        apply(mk(0,1,0, 1,0, 0, 'h00001, 1, 0,0,0,0), 102);

        idle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
